// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue: circular queue of 4-wide fetch bundles between fetch and decode; define NOP_SLOT_SQUASH_EN to mark all-zero instruction slots invalid
module fetch_bundle_queue #(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         fetch_vld,
  input  logic [63:0]                  pc_in,
  input  logic [63:0]                  inst_in,
  input  logic [63:0]                  recv_pc_in,
  input  logic [3:0]                   pred_in,
  output logic                         fetch_rdy,
  input  logic                         dec_rdy,
  output logic                         dec_vld,
  output logic [63:0]                  pc_out,
  output logic [63:0]                  inst_out,
  output logic [63:0]                  recv_pc_out,
  output logic [3:0]                   pred_out,
  output logic [3:0]                   slot_vld,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [195:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop;
  assign fetch_rdy = count != FULL;
  assign dec_vld   = count != '0;
  assign push      = fetch_vld & fetch_rdy & ~flush;
  assign pop       = dec_vld & dec_rdy & ~flush;
  assign {pc_out, inst_out, recv_pc_out, pred_out} = dec_vld ? mem[rd_ptr] : 196'd0;
`ifdef NOP_SLOT_SQUASH_EN
  for (genvar i = 0; i < 4; i++) begin : g_slot
    assign slot_vld[i] = dec_vld & (inst_out[16*i +: 16] != 16'h0000);
  end
`else
  assign slot_vld = {4{dec_vld}};
`endif
  // pointer and occupancy bookkeeping; flush empties the queue and beats any push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
  // bundle storage; contents are never cleared, validity comes from count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {pc_in, inst_in, recv_pc_in, pred_in};
  end
endmodule
